// File: rtl/cla_nibble_seq_ctrl.sv
// cla_nibble_seq_ctrl: WIDTH-bit add/subtract sequenced over a shared external
// 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
module cla_nibble_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] a_r, b_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            last_step;

    assign last_step = (idx == LAST_IDX);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drive the shared slice only while stepping through nibbles
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a   = a_r[{idx, 2'b00} +: 4];
            slice_b   = b_r[{idx, 2'b00} +: 4];
            slice_cin = carry;
        end
    end

    // Operand capture, per-nibble accumulation and flag generation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= op_a;
                        b_r   <= sub ? ~op_b : op_b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= slice_sum;
                    carry <= slice_cout;
                    idx   <= idx + IW'(1);
                    // Flags are formed from the final slice outputs so they
                    // register on the same edge that enters DONE.
                    if (last_step) begin
                        idx  <= '0;
                        cout <= slice_cout;
                        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                (slice_sum[3] != a_r[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Scoreboard testbench for cla_nibble_seq_ctrl with a behavioural 4-bit slice.
module tb_cla_nibble_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, sub, cin;
    logic [15:0] op_a, op_b, result;
    logic        busy, done, cout, ovf;
    logic [3:0]  slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_cout;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        int          t;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    cla_nibble_seq_ctrl #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sub        (sub),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .ovf        (ovf),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;

    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: result %0h with empty scoreboard", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("cout", 32'(cout), 32'(e.co));
                check("ovf", 32'(ovf), 32'(e.ov));
                check("latency", 32'(cyc - e.t), 32'd5);
            end
        end
    end

    task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] er, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; sub = s; op_a = a; op_b = b; cin = c;
        e.res = er; e.co = ec; e.ov = eo; e.t = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        op_a = ~a; op_b = ~b; cin = ~c; sub = ~s;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_slice", 32'({slice_a, slice_b, slice_cin}), 0);
        rst = 1'b0;

        issue(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        wait_drain();
        issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        wait_drain();
        issue(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        wait_drain();
        issue(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        wait_drain();
        issue(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        wait_drain();

        check("hold_result", 32'(result), 32'h7FFF);
        check("hold_cout", 32'(cout), 1);
        check("hold_ovf", 32'(ovf), 1);
        check("idle_slice", 32'({slice_a, slice_b, slice_cin}), 0);

        // Abort a subtract with reset in its second RUN cycle
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b1; op_a = 16'h1234; op_b = 16'h0007; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("run0_slice_a", 32'(slice_a), 32'h4);
        check("run0_slice_b", 32'(slice_b), 32'h8);
        check("run0_slice_cin", 32'(slice_cin), 1);
        check("start_clr_cout", 32'(cout), 0);
        check("start_clr_ovf", 32'(ovf), 0);
        check("run_busy", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        check("run1_slice_a", 32'(slice_a), 32'h3);
        check("run1_slice_b", 32'(slice_b), 32'hF);
        check("run1_slice_cin", 32'(slice_cin), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_result", 32'(result), 0);
        check("abort_flags", 32'({cout, ovf}), 0);
        check("abort_slice", 32'({slice_a, slice_b, slice_cin}), 0);
        issue(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        wait_drain();

        // start while busy is ignored; start right after done is accepted
        begin
            exp_t e;
            @(posedge clk); #1;
            start = 1'b1; sub = 1'b0; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0;
            e.res = 16'h3333; e.co = 1'b0; e.ov = 1'b0; e.t = cyc;
            q.push_back(e);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
            check("busy_in_run", 32'(busy), 1);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            start = 1'b1; op_a = 16'hBBBB; op_b = 16'h4444; sub = 1'b1;
            check("done_cycle", 32'(done), 1);
            @(posedge clk); #1;
            check("idle_after_done", 32'(busy), 0);
            start = 1'b1; sub = 1'b0; op_a = 16'h0001; op_b = 16'h0002; cin = 1'b0;
            e.res = 16'h0003; e.co = 1'b0; e.ov = 1'b0; e.t = cyc;
            q.push_back(e);
            @(posedge clk); #1;
            start = 1'b0;
            wait_drain();
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
